// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions used by the decode-stage hazard controller.
//   - hz_state_e  : hazard FSM encodings (also exported on state_o for debug)
//   - hz_action_e : what the controller does in the current cycle
//   - hz_ctrl_t   : the six pipeline-register enables driven per cycle
//   - ctrl_of()   : maps an action onto its register enables
//   - NOP_INSTR   : encoding loaded into IF/ID by a flush
package pipeline_pkg;

  localparam int DEFAULT_REG_ADDR_W = 3;

  // Wide enough for the largest legal flush length (7).
  localparam int FLUSH_CNT_W = 3;

  // addi x0, x0, 0: the instruction word a cleared IF/ID register holds.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_BR_FLUSH = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_e;

  typedef enum logic [2:0] {
    ACT_RESET,     // rst low: pipeline held empty
    ACT_HOLD,      // unit disabled: pass-through, state frozen
    ACT_PASS,      // no hazard
    ACT_FREEZE,    // data memory busy: nothing moves, nothing clears
    ACT_LOAD_USE,  // one bubble into ID/EX, PC and IF/ID hold
    ACT_BR_NEW,    // fresh taken branch: start a full flush window
    ACT_BR_CONT    // continue a flush window from the held counter
  } hz_action_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
  } hz_ctrl_t;

  function automatic hz_ctrl_t ctrl_of(input hz_action_e act);
    hz_ctrl_t c;
    c = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};  // pass-through
    case (act)
      ACT_RESET:    c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      ACT_FREEZE:   c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      ACT_LOAD_USE: c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      ACT_BR_NEW,
      ACT_BR_CONT:  c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      default:      ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock, rising edge
//   clr   : synchronous clear (highest priority)
//   inc   : count one when not already at all-ones
//   count : current value; sticks at all-ones, never wraps
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Decode-stage hazard controller. Drives the stall/flush enables of the
// PC, IF/ID, ID/EX and EX/MEM registers for load-use hazards, taken
// branches resolved in EX, and data-memory stalls.
//   clk, rst            : clock; synchronous active-low reset
//   en                  : unit enable (0 = pass-through, state holds)
//   id_rsrc1/2, id_use1/2 : source registers of the ID instruction
//   ex_rdst, ex_mem_read  : destination / load flag of the EX instruction
//   branch_taken        : taken branch in EX (one-cycle pulse)
//   mem_busy            : data memory not ready this cycle
//   pc_write .. ex_mem_write : pipeline register enables (combinational)
//   bubble_cnt          : saturating count of id_ex_flush cycles
//   state_o             : current FSM state for debug
module hazard_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W   = DEFAULT_REG_ADDR_W,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [REG_ADDR_W-1:0] id_rsrc1,
  input  logic [REG_ADDR_W-1:0] id_rsrc2,
  input  logic                  id_use1,
  input  logic                  id_use2,
  input  logic [REG_ADDR_W-1:0] ex_rdst,
  input  logic                  ex_mem_read,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_write,
  output logic                  id_ex_flush,
  output logic                  ex_mem_write,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [1:0]            state_o
);

  // The branch cycle itself is the first flush cycle; the counter holds
  // how many flush cycles remain after it.
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  hz_state_e              state, state_nxt;
  logic [FLUSH_CNT_W-1:0] flush_cnt, flush_cnt_nxt;
  logic                   branch_pending, branch_pending_nxt;
  logic                   lu;
  hz_action_e             act;
  hz_ctrl_t               ctrl;

  assign lu = ex_mem_read & ((id_use1 & (id_rsrc1 == ex_rdst)) |
                             (id_use2 & (id_rsrc2 == ex_rdst)));

  // Action select. Priority: mem_busy > branch (live or pending) > lu.
  // NOTE: every variable written in always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    act = ACT_PASS;
    if (!rst) begin
      act = ACT_RESET;
    end else if (!en) begin
      act = ACT_HOLD;
    end else begin
      case (state)
        HZ_RUN: begin
          if (mem_busy)          act = ACT_FREEZE;
          else if (branch_taken) act = ACT_BR_NEW;
          else if (lu)           act = ACT_LOAD_USE;
        end
        HZ_BR_FLUSH: begin
          if (mem_busy)          act = ACT_FREEZE;
          else if (branch_taken) act = ACT_BR_NEW;
          else                   act = ACT_BR_CONT;
        end
        HZ_MEM_WAIT: begin
          if (mem_busy)            act = ACT_FREEZE;
          else if (branch_taken)   act = ACT_BR_NEW;
          // A zero counter means the deferred branch never started flushing.
          else if (branch_pending) act = (flush_cnt != '0) ? ACT_BR_CONT : ACT_BR_NEW;
          else if (lu)             act = ACT_LOAD_USE;
        end
        default: act = ACT_PASS;
      endcase
    end
  end

  // Next-state logic driven by the selected action.
  always_comb begin
    state_nxt          = state;
    flush_cnt_nxt      = flush_cnt;
    branch_pending_nxt = branch_pending;
    case (act)
      ACT_FREEZE: begin
        state_nxt = HZ_MEM_WAIT;
        if (branch_taken) begin
          // A branch arriving during a stall gets a full flush window later.
          branch_pending_nxt = 1'b1;
          flush_cnt_nxt      = '0;
        end else if (state == HZ_BR_FLUSH) begin
          // Interrupted flush: keep the remaining count and resume it.
          branch_pending_nxt = 1'b1;
        end
      end
      ACT_BR_NEW: begin
        branch_pending_nxt = 1'b0;
        if (FLUSH_CYCLES > 1) begin
          state_nxt     = HZ_BR_FLUSH;
          flush_cnt_nxt = FLUSH_RELOAD;
        end else begin
          state_nxt     = HZ_RUN;
          flush_cnt_nxt = '0;
        end
      end
      ACT_BR_CONT: begin
        branch_pending_nxt = 1'b0;
        if (flush_cnt <= FLUSH_CNT_W'(1)) begin
          state_nxt     = HZ_RUN;
          flush_cnt_nxt = '0;
        end else begin
          state_nxt     = HZ_BR_FLUSH;
          flush_cnt_nxt = flush_cnt - 1'b1;
        end
      end
      ACT_PASS, ACT_LOAD_USE: begin
        state_nxt          = HZ_RUN;
        flush_cnt_nxt      = '0;
        branch_pending_nxt = 1'b0;
      end
      default: ;  // reset is applied by the register; hold keeps everything
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= HZ_RUN;
      flush_cnt      <= '0;
      branch_pending <= 1'b0;
    end else begin
      state          <= state_nxt;
      flush_cnt      <= flush_cnt_nxt;
      branch_pending <= branch_pending_nxt;
    end
  end

  assign ctrl         = ctrl_of(act);
  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_write  = ctrl.id_ex_write;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_write = ctrl.ex_mem_write;
  assign state_o      = state;

  // id_ex_flush is forced high during reset, so clear must win over inc.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .clr   (~rst),
    .inc   (id_ex_flush),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit (FLUSH_CYCLES=2, CNT_W=4).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. Each driven cycle pushes its expected outputs, bubble
// count and state onto a scoreboard; the falling-edge sample pops them.
module tb_hazard_unit;

  localparam int CNT_W = 4;

  // Output vector order: {pc_write, if_id_write, if_id_flush,
  //                       id_ex_write, id_ex_flush, ex_mem_write}
  localparam logic [5:0] O_PASS = 6'b110101;
  localparam logic [5:0] O_FRZ  = 6'b000000;
  localparam logic [5:0] O_LU   = 6'b000111;
  localparam logic [5:0] O_BR   = 6'b111111;
  localparam logic [5:0] O_RST  = 6'b001010;

  typedef struct {
    bit       rst;
    bit       en;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    bit       u1;
    bit       u2;
    bit       mr;
    bit       br;
    bit       mb;
  } stim_t;

  typedef struct {
    logic [5:0]       outs;
    logic [CNT_W-1:0] bub;
    logic [1:0]       st;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, en, id_use1, id_use2, ex_mem_read, branch_taken, mem_busy;
  logic [2:0]       id_rsrc1, id_rsrc2, ex_rdst;
  logic             pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write;
  logic [CNT_W-1:0] bubble_cnt;
  logic [1:0]       state_o;
  logic [5:0]       outs;

  exp_t             sb[$];
  logic [CNT_W-1:0] exp_bub = '0;
  int               n_cmp = 0;
  int               n_bad = 0;

  always #5 clk = ~clk;

  assign outs = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write};

  hazard_unit #(
    .REG_ADDR_W   (3),
    .FLUSH_CYCLES (2),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .id_rsrc1     (id_rsrc1),
    .id_rsrc2     (id_rsrc2),
    .id_use1      (id_use1),
    .id_use2      (id_use2),
    .ex_rdst      (ex_rdst),
    .ex_mem_read  (ex_mem_read),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_write  (id_ex_write),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_write (ex_mem_write),
    .bubble_cnt   (bubble_cnt),
    .state_o      (state_o)
  );

  function automatic stim_t mk(input bit br, input bit mb, input bit mr, input logic [2:0] rd,
                               input logic [2:0] rs1, input bit u1, input logic [2:0] rs2,
                               input bit u2);
    stim_t s;
    s.rst = 1'b1; s.en = 1'b1;
    s.br = br; s.mb = mb; s.mr = mr; s.rd = rd;
    s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
  endfunction

  // Load whose destination r3 is read as rsrc1 by the ID instruction.
  function automatic stim_t lu_stim();
    return mk(0, 0, 1, 3'd3, 3'd3, 1, 3'd5, 0);
  endfunction

  function automatic stim_t with_rst0(input stim_t s);
    stim_t r;
    r = s; r.rst = 1'b0;
    return r;
  endfunction

  function automatic stim_t with_en0(input stim_t s);
    stim_t r;
    r = s; r.en = 1'b0;
    return r;
  endfunction

  function automatic stim_t with_br(input stim_t s, input bit mb);
    stim_t r;
    r = s; r.br = 1'b1; r.mb = mb;
    return r;
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst; en = s.en; id_rsrc1 = s.rs1; id_rsrc2 = s.rs2;
    id_use1 = s.u1; id_use2 = s.u2; ex_rdst = s.rd; ex_mem_read = s.mr;
    branch_taken = s.br; mem_busy = s.mb;
  endtask

  // Drive one cycle and record what the outputs must be during it. The
  // bench's own bubble model follows the expected id_ex_flush bit.
  task automatic drive(input stim_t s, input logic [5:0] eo, input logic [1:0] es);
    exp_t e;
    @(posedge clk); #1;
    apply(s);
    e.outs = eo; e.bub = exp_bub; e.st = es;
    sb.push_back(e);
    if (!s.rst) exp_bub = '0;
    else if (eo[1] && (exp_bub != '1)) exp_bub = exp_bub + 1'b1;
  endtask

  // Unchecked reset cycle that puts the DUT in a known state between tests.
  task automatic reset_quiet();
    @(posedge clk); #1;
    apply(with_rst0(idle()));
    exp_bub = '0;
  endtask

  task automatic test_reset();
    stim_t s[$]; logic [5:0] eo[$]; logic [1:0] es[$]; exp_t e;
    s.push_back(with_rst0(idle()));     eo.push_back(O_RST);  es.push_back(2'd0);
    s.push_back(with_rst0(lu_stim()));  eo.push_back(O_RST);  es.push_back(2'd0);
    s.push_back(idle());                eo.push_back(O_PASS); es.push_back(2'd0);
    s.push_back(with_en0(idle()));      eo.push_back(O_PASS); es.push_back(2'd0);
    foreach (s[i]) begin
      drive(s[i], eo[i], es[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({outs, bubble_cnt, state_o} !== {e.outs, e.bub, e.st}) begin
        n_bad++;
        $display("FAIL reset[%0d]: outs=%b bub=%0d st=%0d, expected outs=%b bub=%0d st=%0d",
                 i, outs, bubble_cnt, state_o, e.outs, e.bub, e.st);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t s[$]; logic [5:0] eo[$]; logic [1:0] es[$]; exp_t e;
    reset_quiet();
    s.push_back(lu_stim());                           eo.push_back(O_LU);   es.push_back(2'd0);
    s.push_back(idle());                              eo.push_back(O_PASS); es.push_back(2'd0);
    // Match through rsrc2 on register 0, which is an ordinary register.
    s.push_back(mk(0, 0, 1, 3'd0, 3'd5, 0, 3'd0, 1)); eo.push_back(O_LU);   es.push_back(2'd0);
    s.push_back(idle());                              eo.push_back(O_PASS); es.push_back(2'd0);
    foreach (s[i]) begin
      drive(s[i], eo[i], es[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({outs, bubble_cnt, state_o} !== {e.outs, e.bub, e.st}) begin
        n_bad++;
        $display("FAIL load_use[%0d]: outs=%b bub=%0d st=%0d, expected outs=%b bub=%0d st=%0d",
                 i, outs, bubble_cnt, state_o, e.outs, e.bub, e.st);
      end
    end
  endtask

  task automatic test_no_false_hazard();
    stim_t s[$]; logic [5:0] eo[$]; logic [1:0] es[$]; exp_t e;
    reset_quiet();
    s.push_back(mk(0, 0, 1, 3'd3, 3'd3, 0, 3'd3, 0)); eo.push_back(O_PASS); es.push_back(2'd0);
    s.push_back(mk(0, 0, 0, 3'd3, 3'd3, 1, 3'd3, 1)); eo.push_back(O_PASS); es.push_back(2'd0);
    s.push_back(mk(0, 0, 1, 3'd3, 3'd2, 1, 3'd4, 1)); eo.push_back(O_PASS); es.push_back(2'd0);
    s.push_back(idle());                              eo.push_back(O_PASS); es.push_back(2'd0);
    foreach (s[i]) begin
      drive(s[i], eo[i], es[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({outs, bubble_cnt, state_o} !== {e.outs, e.bub, e.st}) begin
        n_bad++;
        $display("FAIL no_false_hazard[%0d]: outs=%b bub=%0d st=%0d, expected outs=%b bub=%0d st=%0d",
                 i, outs, bubble_cnt, state_o, e.outs, e.bub, e.st);
      end
    end
  endtask

  task automatic test_branch();
    stim_t s[$]; logic [5:0] eo[$]; logic [1:0] es[$]; exp_t e;
    reset_quiet();
    s.push_back(with_br(idle(), 0));    eo.push_back(O_BR);   es.push_back(2'd0);
    s.push_back(idle());                eo.push_back(O_BR);   es.push_back(2'd1);
    s.push_back(idle());                eo.push_back(O_PASS); es.push_back(2'd0);
    // lu ignored under a branch; a second branch restarts the window.
    s.push_back(with_br(lu_stim(), 0)); eo.push_back(O_BR);   es.push_back(2'd0);
    s.push_back(with_br(idle(), 0));    eo.push_back(O_BR);   es.push_back(2'd1);
    s.push_back(idle());                eo.push_back(O_BR);   es.push_back(2'd1);
    s.push_back(idle());                eo.push_back(O_PASS); es.push_back(2'd0);
    foreach (s[i]) begin
      drive(s[i], eo[i], es[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({outs, bubble_cnt, state_o} !== {e.outs, e.bub, e.st}) begin
        n_bad++;
        $display("FAIL branch[%0d]: outs=%b bub=%0d st=%0d, expected outs=%b bub=%0d st=%0d",
                 i, outs, bubble_cnt, state_o, e.outs, e.bub, e.st);
      end
    end
  endtask

  task automatic test_mem_stall();
    stim_t s[$]; logic [5:0] eo[$]; logic [1:0] es[$]; exp_t e;
    stim_t busy;
    reset_quiet();
    busy = mk(0, 1, 0, 3'd0, 3'd0, 0, 3'd0, 0);
    // Three frozen cycles with a branch in the second, then its flush.
    s.push_back(busy);                  eo.push_back(O_FRZ);  es.push_back(2'd0);
    s.push_back(with_br(idle(), 1));    eo.push_back(O_FRZ);  es.push_back(2'd2);
    s.push_back(busy);                  eo.push_back(O_FRZ);  es.push_back(2'd2);
    s.push_back(idle());                eo.push_back(O_BR);   es.push_back(2'd2);
    s.push_back(idle());                eo.push_back(O_BR);   es.push_back(2'd1);
    s.push_back(idle());                eo.push_back(O_PASS); es.push_back(2'd0);
    // Stall interrupting a flush: remaining flush cycle resumes afterwards.
    s.push_back(with_br(idle(), 0));    eo.push_back(O_BR);   es.push_back(2'd0);
    s.push_back(busy);                  eo.push_back(O_FRZ);  es.push_back(2'd1);
    s.push_back(idle());                eo.push_back(O_BR);   es.push_back(2'd2);
    s.push_back(idle());                eo.push_back(O_PASS); es.push_back(2'd0);
    // Load-use masked by the stall, then seen on release.
    busy = lu_stim(); busy.mb = 1'b1;
    s.push_back(busy);                  eo.push_back(O_FRZ);  es.push_back(2'd0);
    s.push_back(lu_stim());             eo.push_back(O_LU);   es.push_back(2'd2);
    s.push_back(idle());                eo.push_back(O_PASS); es.push_back(2'd0);
    foreach (s[i]) begin
      drive(s[i], eo[i], es[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({outs, bubble_cnt, state_o} !== {e.outs, e.bub, e.st}) begin
        n_bad++;
        $display("FAIL mem_stall[%0d]: outs=%b bub=%0d st=%0d, expected outs=%b bub=%0d st=%0d",
                 i, outs, bubble_cnt, state_o, e.outs, e.bub, e.st);
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    stim_t s[$]; logic [5:0] eo[$]; logic [1:0] es[$]; exp_t e;
    reset_quiet();
    s.push_back(with_br(idle(), 0));    eo.push_back(O_BR);   es.push_back(2'd0);
    s.push_back(with_rst0(idle()));     eo.push_back(O_RST);  es.push_back(2'd1);
    s.push_back(idle());                eo.push_back(O_PASS); es.push_back(2'd0);
    // Pending branch recorded during a stall must be dropped by reset.
    s.push_back(with_br(idle(), 1));    eo.push_back(O_FRZ);  es.push_back(2'd0);
    s.push_back(with_rst0(idle()));     eo.push_back(O_RST);  es.push_back(2'd2);
    s.push_back(idle());                eo.push_back(O_PASS); es.push_back(2'd0);
    s.push_back(idle());                eo.push_back(O_PASS); es.push_back(2'd0);
    foreach (s[i]) begin
      drive(s[i], eo[i], es[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({outs, bubble_cnt, state_o} !== {e.outs, e.bub, e.st}) begin
        n_bad++;
        $display("FAIL reset_mid_flush[%0d]: outs=%b bub=%0d st=%0d, expected outs=%b bub=%0d st=%0d",
                 i, outs, bubble_cnt, state_o, e.outs, e.bub, e.st);
      end
    end
  endtask

  task automatic test_saturation_enable();
    stim_t s[$]; logic [5:0] eo[$]; logic [1:0] es[$]; exp_t e;
    stim_t all_on;
    reset_quiet();
    // Twenty load-use cycles alternating the matching source operand.
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) s.push_back(mk(0, 0, 1, 3'd3, 3'd3, 1, 3'd0, 0));
      else            s.push_back(mk(0, 0, 1, 3'd6, 3'd1, 0, 3'd6, 1));
      eo.push_back(O_LU); es.push_back(2'd0);
    end
    s.push_back(idle());                eo.push_back(O_PASS); es.push_back(2'd0);
    s.push_back(with_br(idle(), 0));    eo.push_back(O_BR);   es.push_back(2'd0);
    s.push_back(with_en0(idle()));      eo.push_back(O_PASS); es.push_back(2'd1);
    all_on = with_br(lu_stim(), 1);
    s.push_back(with_en0(all_on));      eo.push_back(O_PASS); es.push_back(2'd1);
    s.push_back(idle());                eo.push_back(O_BR);   es.push_back(2'd1);
    s.push_back(idle());                eo.push_back(O_PASS); es.push_back(2'd0);
    foreach (s[i]) begin
      drive(s[i], eo[i], es[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({outs, bubble_cnt, state_o} !== {e.outs, e.bub, e.st}) begin
        n_bad++;
        $display("FAIL saturation_enable[%0d]: outs=%b bub=%0d st=%0d, expected outs=%b bub=%0d st=%0d",
                 i, outs, bubble_cnt, state_o, e.outs, e.bub, e.st);
      end
    end
  endtask

  initial begin
    apply(with_rst0(idle()));
    repeat (2) @(posedge clk);
    exp_bub = '0;
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_branch();
    test_mem_stall();
    test_reset_mid_flush();
    test_saturation_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
